// File: rtl/sum_accumulator.sv
// sum_accumulator: takes a handshaked burst of W-bit operands, each with its
// own carry-in, and adds them into a running W-bit sum through a ripple adder.
// It reports the wrapped sum, a sticky carry-out and a term count, then pulses
// done for one cycle.
module sum_accumulator #(
    parameter int unsigned W     = 5,
    parameter int unsigned N_MAX = 15,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_ci,
    input  logic             in_last,
    output logic [W-1:0]     acc,
    output logic             cout_sticky,
    output logic [CNT_W-1:0] term_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NMaxCnt = CNT_W'(N_MAX);

    state_t             r_state;
    state_t             w_state_next;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       w_acc_next;
    logic               r_cout;
    logic               w_cout_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_done;

    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [W-1:0]       w_sum;
    logic [W:0]         w_carry;

    // Ripple-carry adder: running sum plus operand plus per-beat carry-in.
    assign w_carry[0] = in_ci;
    for (genvar g = 0; g < W; g++) begin : g_ripple
        assign w_sum[g]       = r_acc[g] ^ in_data[g] ^ w_carry[g];
        assign w_carry[g + 1] = (r_acc[g] & in_data[g]) |
                                (r_acc[g] & w_carry[g]) |
                                (in_data[g] & w_carry[g]);
    end

    // A restart request blocks acceptance in the same cycle.
    assign in_ready  = (r_state == StAccum) && !start;
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Next-state logic for the FSM and the result registers.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cout_next  = r_cout;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StAccum;
                    w_acc_next   = '0;
                    w_cout_next  = 1'b0;
                    w_cnt_next   = '0;
                end
            end
            StAccum: begin
                if (start) begin
                    w_acc_next  = '0;
                    w_cout_next = 1'b0;
                    w_cnt_next  = '0;
                end else if (w_accept) begin
                    w_acc_next  = w_sum;
                    w_cout_next = r_cout | w_carry[W];
                    w_cnt_next  = w_cnt_inc;
                    if (in_last || (w_cnt_inc == NMaxCnt)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    w_state_next = StAccum;
                    w_acc_next   = '0;
                    w_cout_next  = 1'b0;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cout  <= w_cout_next;
            r_cnt   <= w_cnt_next;
            r_done  <= (w_state_next == StDone);
        end
    end

    assign acc         = r_acc;
    assign cout_sticky = r_cout;
    assign term_cnt    = r_cnt;
    assign done        = r_done;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with hand-computed expected values.
module tb_sum_accumulator;

    localparam int W     = 5;
    localparam int N_MAX = 15;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_ci;
    logic             in_last;
    logic [W-1:0]     acc;
    logic             cout_sticky;
    logic [CNT_W-1:0] term_cnt;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    sum_accumulator #(
        .W     (W),
        .N_MAX (N_MAX),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ci       (in_ci),
        .in_last     (in_last),
        .acc         (acc),
        .cout_sticky (cout_sticky),
        .term_cnt    (term_cnt),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input logic ci, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_ci    = ci;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        in_ci    = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        idle_in();

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_ci    = 1'($urandom);
            in_last  = 1'($urandom);
            step();
        end
        check("rst_acc", 8'(acc), 8'h00);
        check("rst_cout", 8'(cout_sticky), 8'h0);
        check("rst_cnt", 8'(term_cnt), 8'h0);
        check("rst_done", 8'(done), 8'h0);
        check("rst_ready", 8'(in_ready), 8'h0);
        rst = 1'b0;
        start = 1'b0;
        idle_in();
        step();
        check("idle_ready", 8'(in_ready), 8'h0);

        // 1b. reset mid-burst
        start = 1'b1;
        step();
        start = 1'b0;
        beat(5'd7, 1'b0, 1'b0);
        step();
        check("mid_acc_pre", 8'(acc), 8'h07);
        rst = 1'b1;
        step();
        check("mid_rst_acc", 8'(acc), 8'h00);
        check("mid_rst_cnt", 8'(term_cnt), 8'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 8'(in_ready), 8'h0);
        idle_in();
        step();
        check("mid_rst_idle_acc", 8'(acc), 8'h00);

        // 2. basic burst
        start = 1'b1;
        step();
        start = 1'b0;
        beat(5'b00001, 1'b0, 1'b0);
        #1;
        check("b2_ready", 8'(in_ready), 8'h1);
        step();
        check("b2_acc1", 8'(acc), 8'h01);
        check("b2_cnt1", 8'(term_cnt), 8'h1);
        check("b2_done_early", 8'(done), 8'h0);
        beat(5'b00010, 1'b0, 1'b1);
        step();
        idle_in();
        check("b2_acc", 8'(acc), 8'h03);
        check("b2_cout", 8'(cout_sticky), 8'h0);
        check("b2_cnt", 8'(term_cnt), 8'h2);
        check("b2_done", 8'(done), 8'h1);
        check("b2_ready_done", 8'(in_ready), 8'h0);
        step();
        check("b2_done_off", 8'(done), 8'h0);
        check("b2_hold_acc", 8'(acc), 8'h03);
        check("b2_hold_cnt", 8'(term_cnt), 8'h2);

        // 3. wrap and carry
        start = 1'b1;
        step();
        start = 1'b0;
        check("b3_clr_acc", 8'(acc), 8'h00);
        check("b3_clr_cnt", 8'(term_cnt), 8'h0);
        beat(5'b11111, 1'b1, 1'b0);
        step();
        check("b3_acc1", 8'(acc), 8'h00);
        check("b3_cout1", 8'(cout_sticky), 8'h1);
        beat(5'b01010, 1'b1, 1'b1);
        step();
        idle_in();
        check("b3_acc", 8'(acc), 8'h0b);
        check("b3_cout", 8'(cout_sticky), 8'h1);
        check("b3_cnt", 8'(term_cnt), 8'h2);
        check("b3_done", 8'(done), 8'h1);
        step();

        // 4. auto-terminate at N_MAX
        start = 1'b1;
        step();
        start = 1'b0;
        check("b4_cout_clr", 8'(cout_sticky), 8'h0);
        for (int i = 1; i <= N_MAX; i++) begin
            beat(5'b00001, 1'b0, 1'b0);
            #1;
            check("b4_ready", 8'(in_ready), 8'h1);
            step();
            check("b4_acc", 8'(acc), 8'(i));
            check("b4_done", 8'(done), (i == N_MAX) ? 8'h1 : 8'h0);
        end
        check("b4_cnt", 8'(term_cnt), 8'h0f);
        check("b4_ready_after", 8'(in_ready), 8'h0);
        step();
        check("b4_acc_held", 8'(acc), 8'h0f);
        check("b4_cnt_held", 8'(term_cnt), 8'h0f);
        check("b4_idle_ready", 8'(in_ready), 8'h0);
        idle_in();
        step();

        // 5. gaps and restart
        start = 1'b1;
        step();
        start = 1'b0;
        beat(5'b00101, 1'b0, 1'b0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            check("b5_gap_acc", 8'(acc), 8'h05);
        end
        start = 1'b1;
        beat(5'b10101, 1'b0, 1'b0);
        #1;
        check("b5_restart_ready", 8'(in_ready), 8'h0);
        step();
        start = 1'b0;
        check("b5_restart_acc", 8'(acc), 8'h00);
        check("b5_restart_cnt", 8'(term_cnt), 8'h0);
        beat(5'b10000, 1'b0, 1'b1);
        step();
        idle_in();
        check("b5_acc", 8'(acc), 8'h10);
        check("b5_cnt", 8'(term_cnt), 8'h1);
        check("b5_done", 8'(done), 8'h1);
        step();

        // 6. back-to-back bursts
        start = 1'b1;
        step();
        start = 1'b0;
        beat(5'b00011, 1'b0, 1'b1);
        step();
        idle_in();
        check("b6_acc1", 8'(acc), 8'h03);
        check("b6_done1", 8'(done), 8'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("b6_done_once", 8'(done), 8'h0);
        check("b6_clr_acc", 8'(acc), 8'h00);
        check("b6_clr_cnt", 8'(term_cnt), 8'h0);
        #1;
        check("b6_ready", 8'(in_ready), 8'h1);
        beat(5'b11100, 1'b0, 1'b1);
        step();
        idle_in();
        check("b6_acc", 8'(acc), 8'h1c);
        check("b6_cout", 8'(cout_sticky), 8'h0);
        check("b6_done2", 8'(done), 8'h1);
        step();
        check("b6_done2_off", 8'(done), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
